mem_reg_responder: RTL and testbench

- Responder (slave) end of the single-cycle valid/wr_en/addr/wdata/rdata memory bus that the verification environment drives as initiator.
- Implements a small register map: control, interrupt status, compare, a free-running counter, scratch, ID and an unmapped-access error count.
- Serves as the DUT for RAL front-door/back-door checks and drives one interrupt output.

---
 rtl/mem_reg_responder_pkg.sv | 37 +++
 rtl/mem_reg_responder_if.sv | 16 +
 rtl/mem_reg_responder_counter.sv | 37 +++
 rtl/mem_reg_responder.sv | 141 ++++++++++++++
 tb/tb_mem_reg_responder.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/mem_reg_responder_pkg.sv
// Shared definitions for the mem_reg responder register map.
// Offsets, CTRL bit positions, the CTRL layout struct, the access
// classification enum and a saturating-increment helper. The RAL model
// generator consumes this package as well, so keep offsets authoritative here.
package mem_reg_pkg;

  localparam logic [7:0] CTRL_OFS     = 8'h00;
  localparam logic [7:0] INT_STAT_OFS = 8'h04;
  localparam logic [7:0] COMPARE_OFS  = 8'h08;
  localparam logic [7:0] COUNT_OFS    = 8'h0C;
  localparam logic [7:0] SCRATCH_OFS  = 8'h10;
  localparam logic [7:0] ID_OFS       = 8'h14;
  localparam logic [7:0] ERR_CNT_OFS  = 8'h18;

  localparam int CTRL_CNT_EN_BIT  = 0;
  localparam int CTRL_IRQ_EN_BIT  = 1;
  localparam int CTRL_CNT_CLR_BIT = 2;

  // Field order mirrors the bit indices above: {cnt_clr, irq_en, cnt_en}.
  typedef struct packed {
    logic cnt_clr;
    logic irq_en;
    logic cnt_en;
  } ctrl_t;

  typedef enum logic [1:0] {
    ACC_NONE,
    ACC_RD,
    ACC_WR,
    ACC_ERR
  } acc_e;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/mem_reg_responder_if.sv
// Single-cycle memory bus between an initiator (master) and the register
// responder (slave).
//   addr/wr_en/valid/wdata : initiator -> responder, one access per strobe
//   rdata                  : registered read data, valid the cycle after a read
//   irq                    : level interrupt from the responder
interface mem_reg_responder_if;
  logic [31:0] addr;
  logic        wr_en;
  logic        valid;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  modport master (output addr, wr_en, valid, wdata, input rdata, irq);
  modport slave  (input addr, wr_en, valid, wdata, output rdata, irq);
endinterface

// File: rtl/mem_reg_responder_counter.sv
// Free-running COUNT register with clear/enable priority and compare match.
//   clk_i, rst_i   : clock, synchronous active-high reset
//   cnt_en_i       : registered CTRL.cnt_en (pre-update value)
//   clr_i          : CTRL write with cnt_clr set this cycle
//   compare_i      : registered COMPARE value
//   count_o        : current COUNT (pre-update at the coming edge)
//   match_o        : high when this edge should set INT_STAT.match
module mem_reg_counter (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cnt_en_i,
  input  logic        clr_i,
  input  logic [31:0] compare_i,
  output logic [31:0] count_o,
  output logic        match_o
);

  logic [31:0] count_q, count_d;

  // Clear beats increment; increment wraps naturally at 32 bits.
  always_comb begin
    count_d = count_q;
    if (clr_i)         count_d = '0;
    else if (cnt_en_i) count_d = count_q + 32'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) count_q <= '0;
    else       count_q <= count_d;
  end

  // Compare uses pre-update values, so a match at COUNT==COMPARE is seen on
  // the edge where COUNT leaves that value.
  assign match_o = cnt_en_i & (count_q == compare_i);
  assign count_o = count_q;

endmodule

// File: rtl/mem_reg_responder.sv
// Register-map responder on the single-cycle memory bus.
//   clk  : bus clock
//   rst  : synchronous active-high reset, wins over any same-cycle access
//   bus  : slave modport (addr, wr_en, valid, wdata in; rdata, irq out)
// Map: CTRL, INT_STAT (W1C), COMPARE, COUNT (RO), SCRATCH, ID (RO),
// ERR_CNT (RO, counts unmapped/misaligned/off-base accesses, saturating).
module mem_reg_responder
  import mem_reg_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter logic [31:0] ID_VALUE       = 32'h5241_4C01,
  parameter logic [31:0] SCRATCH_RST    = 32'hDEAD_BEEF,
  parameter logic [31:0] UNMAPPED_RDATA = 32'hBAD0_ADD0
) (
  input  logic                clk,
  input  logic                rst,
  mem_reg_responder_if.slave  bus
);

  ctrl_t       ctrl_q, ctrl_d;
  logic        match_q, match_d;
  logic [31:0] compare_q, compare_d;
  logic [31:0] scratch_q, scratch_d;
  logic [31:0] err_cnt_q, err_cnt_d;
  logic [31:0] rdata_q, rdata_d;

  logic [7:0]  ofs;
  logic        ofs_ok;
  acc_e        acc;
  logic [31:0] rd_val;
  logic [31:0] count;
  logic        match_set;
  logic        cnt_clr;

  assign ofs = bus.addr[7:0];

  always_comb begin
    ofs_ok = 1'b0;
    case (ofs)
      CTRL_OFS, INT_STAT_OFS, COMPARE_OFS, COUNT_OFS,
      SCRATCH_OFS, ID_OFS, ERR_CNT_OFS: ofs_ok = 1'b1;
      default:                          ofs_ok = 1'b0;
    endcase
  end

  // Classify the access once; everything downstream keys off acc.
  always_comb begin
    acc = ACC_NONE;
    if (bus.valid) begin
      if ((bus.addr[31:8] != BASE_ADDR[31:8]) || (bus.addr[1:0] != 2'b00) || !ofs_ok)
        acc = ACC_ERR;
      else if (bus.wr_en)
        acc = ACC_WR;
      else
        acc = ACC_RD;
    end
  end

  always_comb begin
    rd_val = '0;
    case (ofs)
      CTRL_OFS:     rd_val = {30'd0, ctrl_q.irq_en, ctrl_q.cnt_en};
      INT_STAT_OFS: rd_val = {31'd0, match_q};
      COMPARE_OFS:  rd_val = compare_q;
      COUNT_OFS:    rd_val = count;
      SCRATCH_OFS:  rd_val = scratch_q;
      ID_OFS:       rd_val = ID_VALUE;
      ERR_CNT_OFS:  rd_val = err_cnt_q;
      default:      rd_val = UNMAPPED_RDATA;
    endcase
  end

  assign cnt_clr = (acc == ACC_WR) && (ofs == CTRL_OFS) && bus.wdata[CTRL_CNT_CLR_BIT];

  mem_reg_counter u_cnt (
    .clk_i     (clk),
    .rst_i     (rst),
    .cnt_en_i  (ctrl_q.cnt_en),
    .clr_i     (cnt_clr),
    .compare_i (compare_q),
    .count_o   (count),
    .match_o   (match_set)
  );

  always_comb begin
    ctrl_d    = ctrl_q;
    match_d   = match_q;
    compare_d = compare_q;
    scratch_d = scratch_q;
    err_cnt_d = err_cnt_q;
    rdata_d   = rdata_q;

    case (acc)
      ACC_RD: rdata_d = rd_val;
      ACC_WR: begin
        case (ofs)
          CTRL_OFS: begin
            ctrl_d.cnt_en = bus.wdata[CTRL_CNT_EN_BIT];
            ctrl_d.irq_en = bus.wdata[CTRL_IRQ_EN_BIT];
          end
          INT_STAT_OFS: if (bus.wdata[0]) match_d = 1'b0;
          COMPARE_OFS:  compare_d = bus.wdata;
          SCRATCH_OFS:  scratch_d = bus.wdata;
          default: ; // COUNT, ID, ERR_CNT are read-only, not errors
        endcase
      end
      ACC_ERR: begin
        err_cnt_d = sat_inc32(err_cnt_q);
        if (!bus.wr_en) rdata_d = UNMAPPED_RDATA;
      end
      default: ;
    endcase

    // cnt_clr is a pulse; it never holds state.
    ctrl_d.cnt_clr = 1'b0;
    // Set after the W1C clear so a same-edge set wins.
    if (match_set) match_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q    <= '0;
      match_q   <= 1'b0;
      compare_q <= '0;
      scratch_q <= SCRATCH_RST;
      err_cnt_q <= '0;
      rdata_q   <= '0;
    end else begin
      ctrl_q    <= ctrl_d;
      match_q   <= match_d;
      compare_q <= compare_d;
      scratch_q <= scratch_d;
      err_cnt_q <= err_cnt_d;
      rdata_q   <= rdata_d;
    end
  end

  assign bus.rdata = rdata_q;
  assign bus.irq   = match_q & ctrl_q.irq_en;

endmodule

// File: tb/tb_mem_reg_responder.sv
module tb_mem_reg_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  mem_reg_responder_if bus();

  mem_reg_responder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference model: word-indexed register file.
  // 0 CTRL(bits1:0) 1 INT_STAT 2 COMPARE 3 COUNT 4 SCRATCH 5 ID 6 ERR_CNT
  logic [31:0] mreg [7];
  logic [31:0] m_rdata;

  task automatic model_reset();
    mreg[0] = 0; mreg[1] = 0; mreg[2] = 0; mreg[3] = 0;
    mreg[4] = 32'hDEAD_BEEF; mreg[5] = 32'h5241_4C01; mreg[6] = 0;
    m_rdata = 0;
  endtask

  task automatic model_step(input logic v, input logic w, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] old [7];
    logic        mapped;
    int          idx;
    old    = mreg;
    idx    = int'(a[7:2]);
    mapped = (a[31:8] == 24'd0) && (a[1:0] == 2'b00) && (idx < 7);
    if (v && !mapped) begin
      if (old[6] != 32'hFFFF_FFFF) mreg[6] = old[6] + 1;
      if (!w) m_rdata = 32'hBAD0_ADD0;
    end
    if (v && mapped && !w) m_rdata = old[idx];
    if (v && mapped && w && idx == 0 && d[2]) mreg[3] = 0;
    else if (old[0][0])                       mreg[3] = old[3] + 1;
    if (v && mapped && w) begin
      if (idx == 0) mreg[0] = d & 32'h3;
      if (idx == 1 && d[0]) mreg[1] = 0;
      if (idx == 2) mreg[2] = d;
      if (idx == 4) mreg[4] = d;
    end
    if (old[0][0] && old[3] == old[2]) mreg[1] = 1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One bus cycle: drive at negedge, model updates at posedge, compare at next negedge.
  task automatic step(input logic v, input logic w, input logic [31:0] a, input logic [31:0] d);
    bus.valid = v; bus.wr_en = w; bus.addr = a; bus.wdata = d;
    @(posedge clk);
    model_step(v, w, a, d);
    @(negedge clk);
    chk("rdata", bus.rdata, m_rdata);
    chk("irq", {31'd0, bus.irq}, {31'd0, mreg[1][0] & mreg[0][1]});
  endtask

  task automatic rd(input logic [31:0] a);
    step(1'b1, 1'b0, a, 32'd0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    step(1'b1, 1'b1, a, d);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  initial begin
    logic [31:0] a;
    int          r;
    bus.valid = 0; bus.wr_en = 0; bus.addr = 0; bus.wdata = 0;
    model_reset();

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rdata", bus.rdata, 32'd0);
    chk("rst_irq", {31'd0, bus.irq}, 32'd0);
    rst = 0;
    for (int i = 0; i < 7; i++) rd(32'(i * 4));
    rd(32'h10); chk("scratch_rst", bus.rdata, 32'hDEAD_BEEF);
    rd(32'h14); chk("id_val", bus.rdata, 32'h5241_4C01);

    // SCRATCH write/read, RO write ignored
    wr(32'h10, 32'h1234_5678);
    rd(32'h10); chk("scratch_wr", bus.rdata, 32'h1234_5678);
    wr(32'h14, 32'h0);
    rd(32'h14); chk("id_ro", bus.rdata, 32'h5241_4C01);
    rd(32'h18); chk("err_after_ro", bus.rdata, 32'd0);

    // Compare match and irq
    wr(32'h08, 32'd5);
    wr(32'h00, 32'h7);
    for (int i = 0; i < 8; i++) idle();
    chk("irq_after_match", {31'd0, bus.irq}, 32'd1);
    // Set and W1C on the same edge: set wins
    wr(32'h08, mreg[3] + 32'd2);
    idle();
    wr(32'h04, 32'h1);
    chk("set_wins", {31'd0, bus.irq}, 32'd1);
    wr(32'h04, 32'h1);
    chk("w1c_clear", {31'd0, bus.irq}, 32'd0);
    wr(32'h00, 32'h0);

    // Back-door preset near wrap, then count through it
    @(negedge clk);
    force dut.u_cnt.count_q = 32'hFFFF_FFFE;
    mreg[3] = 32'hFFFF_FFFE;
    idle();
    release dut.u_cnt.count_q;
    wr(32'h00, 32'h1);
    rd(32'h0C); chk("wrap0", bus.rdata, 32'hFFFF_FFFE);
    rd(32'h0C); chk("wrap1", bus.rdata, 32'hFFFF_FFFF);
    rd(32'h0C); chk("wrap2", bus.rdata, 32'h0000_0000);
    wr(32'h00, 32'h0);

    // Unmapped accesses
    rd(32'h1C);          chk("unmap_rd_1c", bus.rdata, 32'hBAD0_ADD0);
    rd(32'h0C);
    rd(32'h02);          chk("unmap_rd_02", bus.rdata, 32'hBAD0_ADD0);
    wr(32'h100, 32'h0);
    rd(32'h18);          chk("err_cnt3", bus.rdata, 32'd3);
    rd(32'h10);          chk("scratch_kept", bus.rdata, 32'h1234_5678);

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      r = int'($urandom_range(0, 9));
      if (r < 8)       a = 32'(r * 4);
      else if (r == 8) a = 32'($urandom_range(0, 255));
      else             a = $urandom;
      step(($urandom_range(0, 4) != 0), $urandom_range(0, 1) == 1, a, $urandom);
    end
    rd(32'h10);

    // Reset during a SCRATCH write
    bus.valid = 1; bus.wr_en = 1; bus.addr = 32'h10; bus.wdata = 32'h1111_1111;
    rst = 1;
    @(posedge clk);
    model_reset();
    @(negedge clk);
    chk("rst_mid_rdata", bus.rdata, 32'd0);
    chk("rst_mid_irq", {31'd0, bus.irq}, 32'd0);
    rst = 0;
    rd(32'h10); chk("rst_mid_scratch", bus.rdata, 32'hDEAD_BEEF);
    rd(32'h0C); chk("rst_mid_count", bus.rdata, 32'd0);
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
